// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared types and constants for the UART command path
package quad_pkg;

  typedef enum logic [1:0] {
    CMD = 2'd0,
    HI  = 2'd1,
    LO  = 2'd2
  } rx_state_t;

  localparam logic [7:0] RESP_ACK  = 8'hA5;
  localparam int         FRAME_LEN = 3;

endpackage

// File: rtl/uart_cmd_framer.sv
// rtl/uart_cmd_framer.sv - 3-byte command framer with inter-byte timeout
// and single-byte response transmit path with one-entry holding buffer.
module uart_cmd_framer
  import quad_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int CNT_W       = $clog2(TIMEOUT_CYC)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  input  logic [7:0]  resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        frm_err,
  output logic        frm_ovr,
  output logic        resp_drop
);

  rx_state_t        state, state_nxt;
  logic [7:0]       cmd_hold, hi_hold;
  logic [CNT_W-1:0] cnt;
  logic             cap_cmd, cap_hi, frame_done, tmo, term;

  logic             tx_busy, pend_vld;
  logic [7:0]       pend_byte;

  assign clr_rx_rdy = rx_rdy;
  assign term       = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CMD;
    else     state <= state_nxt;
  end

  // A capture always takes priority over the terminal count.
  always_comb begin
    state_nxt  = state;
    cap_cmd    = 1'b0;
    cap_hi     = 1'b0;
    frame_done = 1'b0;
    tmo        = 1'b0;
    case (state)
      CMD: if (rx_rdy) begin cap_cmd = 1'b1; state_nxt = HI; end
      HI: begin
        if (rx_rdy)    begin cap_hi = 1'b1; state_nxt = LO; end
        else if (term) begin tmo = 1'b1; state_nxt = CMD; end
      end
      LO: begin
        if (rx_rdy)    begin frame_done = 1'b1; state_nxt = CMD; end
        else if (term) begin tmo = 1'b1; state_nxt = CMD; end
      end
      default: state_nxt = CMD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_hold <= '0;
      hi_hold  <= '0;
      cnt      <= '0;
      cmd      <= '0;
      data     <= '0;
      cmd_rdy  <= 1'b0;
      frm_err  <= 1'b0;
      frm_ovr  <= 1'b0;
    end else begin
      if (cap_cmd) cmd_hold <= rx_data;
      if (cap_hi)  hi_hold  <= rx_data;
      if (rx_rdy || state_nxt == CMD) cnt <= '0;
      else                            cnt <= cnt + CNT_W'(1);
      if (frame_done) begin
        cmd  <= cmd_hold;
        data <= {hi_hold, rx_data};
      end
      cmd_rdy <= frame_done | (cmd_rdy & ~clr_cmd_rdy);
      frm_ovr <= frame_done & cmd_rdy;
      frm_err <= tmo;
    end
  end

  // tx_done is only meaningful while a byte is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_busy   <= 1'b0;
      pend_vld  <= 1'b0;
      pend_byte <= '0;
      tx_data   <= '0;
      trmt      <= 1'b0;
      resp_drop <= 1'b0;
    end else begin
      trmt      <= 1'b0;
      resp_drop <= 1'b0;
      if (tx_done && tx_busy) begin
        if (pend_vld) begin
          tx_data <= pend_byte;
          trmt    <= 1'b1;
          if (send_resp) pend_byte <= resp;
          else           pend_vld  <= 1'b0;
        end else if (send_resp) begin
          tx_data <= resp;
          trmt    <= 1'b1;
        end else begin
          tx_busy <= 1'b0;
        end
      end else if (send_resp) begin
        if (!tx_busy) begin
          tx_data <= resp;
          trmt    <= 1'b1;
          tx_busy <= 1'b1;
        end else if (!pend_vld) begin
          pend_byte <= resp;
          pend_vld  <= 1'b1;
        end else begin
          resp_drop <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_framer.sv
// tb/tb_uart_cmd_framer.sv - directed scoreboard bench for uart_cmd_framer
module tb_uart_cmd_framer;
  import quad_pkg::*;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        clr_rx_rdy;
  logic        cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = '0;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done = 1'b0;
  logic        frm_err, frm_ovr, resp_drop;

  uart_cmd_framer #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .resp(resp),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done),
    .frm_err(frm_err), .frm_ovr(frm_ovr), .resp_drop(resp_drop)
  );

  initial forever #5 clk = ~clk;

  int checks = 0, errors = 0;
  int clr_cnt = 0, err_cnt = 0, ovr_cnt = 0, drop_cnt = 0, trmt_cnt = 0;
  int trmt_snap;
  logic [24:0] frame_q[$];
  logic [7:0]  tx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops scoreboard entries when the DUT completes a frame or launches a byte.
  initial begin
    logic        prev_rdy;
    logic [24:0] f;
    logic [7:0]  b;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (clr_rx_rdy) clr_cnt++;
      if (frm_err)    err_cnt++;
      if (frm_ovr)    ovr_cnt++;
      if (resp_drop)  drop_cnt++;
      if (!rst && ((cmd_rdy && !prev_rdy) || frm_ovr)) begin
        chk("frame_expected", 32'(frame_q.size() > 0), 1);
        if (frame_q.size() > 0) begin
          f = frame_q.pop_front();
          chk("frm_ovr", 32'(frm_ovr), 32'(f[24]));
          chk("cmd", 32'(cmd), 32'(f[23:16]));
          chk("data", 32'(data), 32'(f[15:0]));
        end
      end
      prev_rdy = cmd_rdy;
      if (trmt) begin
        trmt_cnt++;
        chk("tx_expected", 32'(tx_q.size() > 0), 1);
        if (tx_q.size() > 0) begin
          b = tx_q.pop_front();
          chk("tx_data", 32'(tx_data), 32'(b));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic clr);
    rx_rdy = 1'b1; rx_data = b; clr_cmd_rdy = clr;
    @(posedge clk); #1;
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
  endtask

  task automatic send_rsp(input logic [7:0] b, input logic done);
    send_resp = 1'b1; resp = b; tx_done = done;
    @(posedge clk); #1;
    send_resp = 1'b0; tx_done = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    @(posedge clk); #1;
    tx_done = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(posedge clk); #1;
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cmd_rdy"}, 32'(cmd_rdy), 0);
    chk({tag, "_cmd"}, 32'(cmd), 0);
    chk({tag, "_data"}, 32'(data), 0);
    chk({tag, "_trmt"}, 32'(trmt), 0);
    chk({tag, "_tx_data"}, 32'(tx_data), 0);
    chk({tag, "_frm_err"}, 32'(frm_err), 0);
    chk({tag, "_frm_ovr"}, 32'(frm_ovr), 0);
    chk({tag, "_resp_drop"}, 32'(resp_drop), 0);
  endtask

  initial begin
    rst = 1'b1;
    tick(2);
    chk_all_zero("reset");
    chk("reset_clr_rx_rdy", 32'(clr_rx_rdy), 0);
    rst = 1'b0;
    tick(2);

    // Basic frame with gaps
    frame_q.push_back({1'b0, 8'h02, 16'h1234});
    send_byte(8'h02, 1'b0); tick(10);
    send_byte(8'h12, 1'b0); tick(10);
    chk("pre_done_cmd_rdy", 32'(cmd_rdy), 0);
    send_byte(8'h34, 1'b0);
    chk("latency_cmd_rdy", 32'(cmd_rdy), 1);
    chk("clr_rx_cnt", 32'(clr_cnt), 3);
    tick(5);
    chk("hold_cmd_rdy", 32'(cmd_rdy), 1);
    chk("hold_data", 32'(data), 32'h1234);
    pulse_clr();
    chk("cleared_cmd_rdy", 32'(cmd_rdy), 0);

    // Timeout discards partial frame
    send_byte(8'h05, 1'b0);
    send_byte(8'h7F, 1'b0);
    tick(TO - 2);
    chk("pre_timeout_err", 32'(err_cnt), 0);
    tick(4);
    chk("timeout_err", 32'(err_cnt), 1);
    frame_q.push_back({1'b0, 8'h06, 16'h0001});
    send_byte(8'h06, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
    chk("after_to_cmd", 32'(cmd), 32'h06);
    pulse_clr();

    // Capture on the terminal-count cycle wins
    frame_q.push_back({1'b0, 8'h0B, 16'h0C0D});
    send_byte(8'h0B, 1'b0); tick(TO - 1);
    send_byte(8'h0C, 1'b0); tick(TO - 1);
    send_byte(8'h0D, 1'b0);
    chk("edge_cmd_rdy", 32'(cmd_rdy), 1);
    tick(1);
    chk("edge_no_err", 32'(err_cnt), 1);
    pulse_clr();

    // Overrun, clear in completion cycle
    frame_q.push_back({1'b0, 8'h11, 16'h2233});
    frame_q.push_back({1'b1, 8'h44, 16'h5566});
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b1);
    chk("ovr_cmd_rdy", 32'(cmd_rdy), 1);
    tick(1);
    chk("ovr_cnt", 32'(ovr_cnt), 1);
    pulse_clr();
    chk("ovr_cleared", 32'(cmd_rdy), 0);

    // Transmit with holding buffer
    tx_q.push_back(RESP_ACK);
    send_rsp(RESP_ACK, 1'b0);
    chk("tx1_trmt", 32'(trmt), 1);
    chk("tx1_data", 32'(tx_data), 32'hA5);
    tx_q.push_back(8'h5A);
    send_rsp(8'h5A, 1'b0);
    tick(3);
    chk("held_trmt_cnt", 32'(trmt_cnt), 1);
    chk("held_tx_data", 32'(tx_data), 32'hA5);
    pulse_done();
    chk("tx2_trmt", 32'(trmt), 1);
    chk("tx2_data", 32'(tx_data), 32'h5A);
    tick(2);
    pulse_done();

    // Drop when buffer full, then simultaneous done+send
    tx_q.push_back(8'hA5);
    send_rsp(8'hA5, 1'b0);
    tx_q.push_back(8'h11);
    send_rsp(8'h11, 1'b0);
    send_rsp(8'h22, 1'b0);
    tick(1);
    chk("drop_cnt", 32'(drop_cnt), 1);
    tx_q.push_back(8'h33);
    send_rsp(8'h33, 1'b1);
    chk("sim_trmt", 32'(trmt), 1);
    chk("sim_data", 32'(tx_data), 32'h11);
    tick(2);
    pulse_done();
    chk("tx33_data", 32'(tx_data), 32'h33);
    tx_q.push_back(8'h44);
    send_rsp(8'h44, 1'b1);
    chk("direct_data", 32'(tx_data), 32'h44);
    tick(1);
    chk("no_extra_drop", 32'(drop_cnt), 1);
    pulse_done();

    // Asynchronous reset mid-frame with pending response
    send_byte(8'h07, 1'b0); send_byte(8'h08, 1'b0);
    tx_q.push_back(8'h99);
    send_rsp(8'h99, 1'b0);
    send_rsp(8'hAA, 1'b0);
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    tick(1);
    rst = 1'b0;
    trmt_snap = trmt_cnt;
    tick(2);
    frame_q.push_back({1'b0, 8'h0A, 16'hBBCC});
    send_byte(8'h0A, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0);
    chk("post_rst_cmd_rdy", 32'(cmd_rdy), 1);
    tick(10);
    chk("no_stale_trmt", 32'(trmt_cnt), 32'(trmt_snap));
    tx_q.push_back(8'hA5);
    send_rsp(8'hA5, 1'b0);
    chk("post_rst_trmt", 32'(trmt), 1);
    tick(2);

    chk("frame_q_empty", 32'(frame_q.size()), 0);
    chk("tx_q_empty", 32'(tx_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
